// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Data-memory bus between the NanoRisc memory access unit (master) and the
// data memory (slave). One request/acknowledge transaction at a time.
//
// Signals:
//   busReq    master->slave  request active
//   busWe     master->slave  1 = write, 0 = read; valid while busReq
//   busAddr   master->slave  ADDR_WIDTH-bit address
//   busWData  master->slave  DATA_WIDTH-bit write data
//   busAck    slave->master  transaction complete
//   busRData  slave->master  read data, valid with busAck on reads
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  busReq;
  logic                  busWe;
  logic [ADDR_WIDTH-1:0] busAddr;
  logic [DATA_WIDTH-1:0] busWData;
  logic                  busAck;
  logic [DATA_WIDTH-1:0] busRData;

  modport master (
    output busReq,
    output busWe,
    output busAddr,
    output busWData,
    input  busAck,
    input  busRData
  );

  modport slave (
    input  busReq,
    input  busWe,
    input  busAddr,
    input  busWData,
    output busAck,
    output busRData
  );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Data-memory access unit for the NanoRisc core. On a load or store it latches
// the address (low ADDR_WIDTH bits of memRead) and the store data, runs one
// request/acknowledge transaction on the data-memory bus and, for loads,
// returns the fetched word to the register bank through memWrite, strobed for
// one cycle by RegMemWrite. The core is stalled while the access is pending.
//
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN
//   Defined   : a REQ phase without ack is aborted after TIMEOUT_CYCLES cycles;
//               busError pulses in the DONE cycle and a timed-out load returns
//               all ones.
//   Undefined : REQ waits indefinitely, busError is tied 0.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high
//   memRead      in   current $mem value, low ADDR_WIDTH bits are the address
//   storeData    in   store operand from the register bank
//   isLoad       in   load instruction present
//   isStore      in   store instruction present (wins over isLoad)
//   stall        out  hold PC/instruction (combinational)
//   bus          --   data-memory bus, master side
//   memWrite     out  load result, held until the next load completes
//   RegMemWrite  out  one-cycle write strobe for memWrite
//   busError     out  one-cycle timeout pulse
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] memRead,
  input  logic [DATA_WIDTH-1:0] storeData,
  input  logic                  isLoad,
  input  logic                  isStore,
  output logic                  stall,
  mem_access_unit_if.master     bus,
  output logic [DATA_WIDTH-1:0] memWrite,
  output logic                  RegMemWrite,
  output logic                  busError
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT state;
  stateT stateNext;

  logic accessStart;
  logic timeoutHit;

  assign accessStart = (state == IDLE) && (isLoad || isStore);

  // The bus request is a straight decode of the state register, so it is
  // glitch-free and drops at the same edge that reset clears the FSM.
  assign bus.busReq = (state == REQ);

  // Reset gates the stall so the core is never held while reset is asserted,
  // even when a strobe is already present.
  assign stall = !reset && (accessStart || (state == REQ));

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] toCount;

  // toCount holds the number of REQ cycles already spent without ack; the
  // limit is hit in the REQ cycle that would make it reach TIMEOUT_CYCLES.
  assign timeoutHit = (state == REQ) && !bus.busAck && (toCount == TimeoutLast);

  always_ff @(posedge clock) begin
    if (reset) begin
      toCount <= 8'd0;
    end else if (accessStart) begin
      toCount <= 8'd0;
    end else if ((state == REQ) && !bus.busAck) begin
      toCount <= toCount + 8'd1;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accessStart) begin
          stateNext = REQ;
        end
      end
      REQ: begin
        if (bus.busAck || timeoutHit) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.busAddr  <= '0;
      bus.busWData <= '0;
      bus.busWe    <= 1'b0;
      memWrite     <= '0;
      RegMemWrite  <= 1'b0;
    end else begin
      RegMemWrite <= 1'b0;
      if (accessStart) begin
        bus.busAddr  <= memRead[ADDR_WIDTH-1:0];
        bus.busWData <= storeData;
        // A simultaneous load strobe is dropped: the access is a store.
        bus.busWe    <= isStore;
      end
      if ((state == REQ) && !bus.busWe) begin
        if (bus.busAck) begin
          memWrite    <= bus.busRData;
          RegMemWrite <= 1'b1;
        end else if (timeoutHit) begin
          memWrite    <= '1;
          RegMemWrite <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  // An ack in the limit cycle suppresses timeoutHit, so it completes normally.
  always_ff @(posedge clock) begin
    if (reset) begin
      busError <= 1'b0;
    end else begin
      busError <= timeoutHit;
    end
  end
`else
  assign busError = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] memRead = '0;
  logic [DW-1:0] storeData = '0;
  logic          isLoad = 1'b0;
  logic          isStore = 1'b0;
  logic          stall;
  logic [DW-1:0] memWrite;
  logic          RegMemWrite;
  logic          busError;

  mem_access_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_access_unit #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .memRead(memRead),
    .storeData(storeData),
    .isLoad(isLoad),
    .isStore(isStore),
    .stall(stall),
    .bus(bus),
    .memWrite(memWrite),
    .RegMemWrite(RegMemWrite),
    .busError(busError)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Expected outputs for the current cycle, written by the driver.
  bit            chkEn = 0;
  bit            regChk = 0;
  logic          eStall, eReq, eWe, eRmw, eErr;
  logic [AW-1:0] eAddr;
  logic [DW-1:0] eWd, eMw;

  // Architectural view of the unit: what the bus fields and memWrite hold.
  logic          mWe = 1'b0;
  logic [AW-1:0] mAddr = '0;
  logic [DW-1:0] mWd = '0;
  logic [DW-1:0] mMw = '0;

  int stallCnt, rmwCnt, reqCnt, errCnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chkEn) begin
      chk("stall", 32'(stall), 32'(eStall));
      if (regChk) begin
        chk("busReq", 32'(bus.busReq), 32'(eReq));
        chk("busWe", 32'(bus.busWe), 32'(eWe));
        chk("busAddr", 32'(bus.busAddr), 32'(eAddr));
        chk("busWData", 32'(bus.busWData), 32'(eWd));
        chk("memWrite", 32'(memWrite), 32'(eMw));
        chk("RegMemWrite", 32'(RegMemWrite), 32'(eRmw));
        chk("busError", 32'(busError), 32'(eErr));
      end
      if (stall === 1'b1) stallCnt++;
      if (RegMemWrite === 1'b1) rmwCnt++;
      if (bus.busReq === 1'b1) reqCnt++;
      if (busError === 1'b1) errCnt++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setHeld();
    eWe = mWe; eAddr = mAddr; eWd = mWd; eMw = mMw;
  endtask

  task automatic clearCnt();
    stallCnt = 0; rmwCnt = 0; reqCnt = 0; errCnt = 0;
  endtask

  task automatic idle(input bit ack);
    tick();
    reset = 1'b0; isLoad = 1'b0; isStore = 1'b0;
    memRead = DW'($urandom); bus.busAck = ack; bus.busRData = DW'($urandom);
    eStall = 0; eReq = 0; eRmw = 0; eErr = 0; setHeld();
  endtask

  task automatic resetSeq(input int n, input bit holdLoad);
    for (int j = 0; j < n; j++) begin
      tick();
      reset = 1'b1; isLoad = holdLoad; isStore = 1'b0;
      bus.busAck = 1'($urandom); bus.busRData = DW'($urandom);
      chkEn = 1;
      regChk = (j > 0);
      eStall = 0; eReq = 0; eRmw = 0; eErr = 0;
      if (j == 0) begin
        mWe = 0; mAddr = '0; mWd = '0; mMw = '0;
      end
      setHeld();
    end
  endtask

  // One access as seen by the core: strobe cycle, REQ cycles, DONE cycle.
  // ackAt is the 0-based REQ cycle carrying busAck; abortAt (>=0) asserts
  // reset in that REQ cycle instead of completing.
  task automatic access(input bit ld, input bit st, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                        input int ackAt, input bit spurious, input int abortAt);
    bit isLd;
    bit timedOut;
    int nReq;
    isLd = ld && !st;
`ifdef MEM_ACCESS_TIMEOUT_EN
    timedOut = (ackAt > TO - 1);
    nReq = timedOut ? TO : ackAt + 1;
`else
    timedOut = 0;
    nReq = ackAt + 1;
`endif
    tick();
    reset = 1'b0; isLoad = ld; isStore = st; memRead = addr; storeData = wd;
    bus.busAck = spurious; bus.busRData = DW'($urandom);
    eStall = 1; eReq = 0; eRmw = 0; eErr = 0; setHeld();
    mAddr = addr[AW-1:0]; mWd = wd; mWe = st;
    for (int i = 0; i < nReq; i++) begin
      tick();
      bus.busAck = (i == ackAt);
      bus.busRData = (i == ackAt) ? rd : DW'($urandom);
      if (i == abortAt) begin
        reset = 1'b1;
        eStall = 0; eReq = 1; eRmw = 0; eErr = 0; setHeld();
        mWe = 0; mAddr = '0; mWd = '0; mMw = '0;
        tick();
        reset = 1'b0; isLoad = 1'b0; isStore = 1'b0; bus.busAck = 1'b0;
        eStall = 0; eReq = 0; eRmw = 0; eErr = 0; setHeld();
        return;
      end
      eStall = 1; eReq = 1; eRmw = 0; eErr = 0; setHeld();
    end
    if (isLd) mMw = timedOut ? '1 : rd;
    tick();
    // Strobes and ack in DONE must be ignored.
    isLoad = 1'($urandom); isStore = 1'($urandom); memRead = DW'($urandom);
    bus.busAck = 1'($urandom); bus.busRData = DW'($urandom);
    eStall = 0; eReq = 0; eRmw = isLd; eErr = timedOut; setHeld();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int k, ack, ab, lim;
    bus.busAck = 1'b0;
    bus.busRData = '0;
    clearCnt();

    resetSeq(3, 1'b1);

    // Load right after reset release: 2 REQ cycles, data 8'h02.
    clearCnt();
    access(1'b1, 1'b0, 8'h2A, 8'h00, 8'h02, 1, 1'b0, -1);
    idle(1'b0);
    chk("load stall cycles", 32'(stallCnt), 32'd3);
    chk("load strobe count", 32'(rmwCnt), 32'd1);
    chk("load data literal", 32'(memWrite), 32'h02);
    chk("load addr literal", 32'(bus.busAddr), 32'h2A);
    chk("load we literal", 32'(bus.busWe), 32'd0);

    // Store with immediate ack.
    clearCnt();
    access(1'b0, 1'b1, 8'h10, 8'h55, 8'hEE, 0, 1'b0, -1);
    idle(1'b0);
    chk("store stall cycles", 32'(stallCnt), 32'd2);
    chk("store strobe count", 32'(rmwCnt), 32'd0);
    chk("store we literal", 32'(bus.busWe), 32'd1);
    chk("store wdata literal", 32'(bus.busWData), 32'h55);
    chk("store keeps memWrite", 32'(memWrite), 32'h02);

    // Spurious idle ack, then both strobes high.
    idle(1'b1);
    idle(1'b1);
    clearCnt();
    access(1'b1, 1'b1, 8'h33, 8'hA5, 8'h77, 0, 1'b1, -1);
    idle(1'b0);
    chk("both strobes store", 32'(bus.busWe), 32'd1);
    chk("both strobes no load", 32'(rmwCnt), 32'd0);

    // Reset in the second REQ cycle.
    clearCnt();
    access(1'b1, 1'b0, 8'h44, 8'h00, 8'h99, 5, 1'b0, 1);
    idle(1'b0);
    chk("abort no strobe", 32'(rmwCnt), 32'd0);
    chk("abort memWrite cleared", 32'(memWrite), 32'h00);

    // Ack in the last cycle before the timeout limit completes normally.
    clearCnt();
    access(1'b1, 1'b0, 8'h21, 8'h00, 8'h3C, TO - 1, 1'b0, -1);
    idle(1'b0);
    chk("ack at limit no error", 32'(errCnt), 32'd0);
    chk("ack at limit data", 32'(memWrite), 32'h3C);

    // Load that never sees an ack within 25 REQ cycles.
    clearCnt();
    access(1'b1, 1'b0, 8'h5A, 8'h00, 8'hC3, 25, 1'b0, -1);
    idle(1'b0);
`ifdef MEM_ACCESS_TIMEOUT_EN
    chk("timeout req cycles", 32'(reqCnt), 32'd4);
    chk("timeout error pulses", 32'(errCnt), 32'd1);
    chk("timeout data", 32'(memWrite), 32'hFF);
`else
    chk("no timeout req held", 32'(reqCnt >= 20), 32'd1);
    chk("no timeout error", 32'(errCnt), 32'd0);
    chk("late ack data", 32'(memWrite), 32'hC3);
`endif

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) idle(1'($urandom));
      k = $urandom_range(0, 2);
      ack = $urandom_range(0, 6);
      ab = -1;
      if ($urandom_range(0, 19) == 0) begin
        lim = (ack < TO - 1) ? ack : TO - 1;
        ab = $urandom_range(0, lim);
      end
      access(k != 1, k != 0, DW'($urandom), DW'($urandom), DW'($urandom),
             ack, 1'($urandom), ab);
    end
    idle(1'b0);
    idle(1'b0);
    chkEn = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access unit for the NanoRisc core: the memory-side counterpart of the register bank's `$mem` port. On a load or store instruction it takes the address from `$mem` (the bank's `memRead` output) and the store data from the bank. It then runs a request/acknowledge transaction on the data-memory bus. For loads it returns the fetched byte to the bank through `memWrite`, strobed by `RegMemWrite`. While a transaction is outstanding it stalls the core.

## Interface
- `DATA_WIDTH`, 8, width of data and of `$mem`
- `ADDR_WIDTH`, 8, data-memory address width; must be ≤ `DATA_WIDTH`
- `TIMEOUT_CYCLES`, 15, maximum REQ cycles without ack (used only with `MEM_ACCESS_TIMEOUT_EN`); range 1..255

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `memRead`  in  DATA_WIDTH  current `$mem` value; low `ADDR_WIDTH` bits form the address
- `storeData`  in  DATA_WIDTH  store operand from the register bank (`data1`)
- `isLoad`  in  1  load instruction present this cycle
- `isStore`  in  1  store instruction present this cycle
- `stall`  out  1  hold PC and instruction (combinational)
- `busReq`  out  1  bus request (registered)
- `busWe`  out  1  1 = write, 0 = read; valid while `busReq`
- `busAddr`  out  ADDR_WIDTH  registered address
- `busWData`  out  DATA_WIDTH  registered write data
- `busAck`  in  1  bus completion, sampled only in REQ
- `busRData`  in  DATA_WIDTH  read data, valid with `busAck` on reads
- `memWrite`  out  DATA_WIDTH  load result to register bank
- `RegMemWrite`  out  1  one-cycle write strobe for `memWrite`
- `busError`  out  1  one-cycle timeout pulse; tied 0 without the macro

## Operation
- The FSM has three states: IDLE, REQ and DONE.
- IDLE:
  - On `isLoad | isStore`, latch `busAddr <= memRead[ADDR_WIDTH-1:0]`, `busWData <= storeData` and `busWe <= isStore`, then go to REQ.
  - If both strobes are high, the access is a store; the load is ignored.
- REQ:
  - `busReq` = 1. `busAddr`, `busWData` and `busWe` are held stable.
  - On `busAck`: for a read, latch `memWrite <= busRData`. Then go to DONE.
- DONE:
  - `busReq` = 0.
  - `RegMemWrite` = 1 only if the access was a load.
  - Return to IDLE next cycle.
  - `isLoad`/`isStore` are ignored here; the core retires the instruction in this cycle.
- `stall` = (IDLE & (isLoad | isStore)) | REQ. `stall` is low in DONE and in idle IDLE.
- `busAck` outside REQ is ignored and has no side effects.
- `memWrite` holds its last value until the next load completes.
- No arithmetic is performed; the address is a truncation of `memRead`, with no wrap logic.

## Timing
- Reset values: state IDLE, `busReq` 0, `busWe` 0, `busAddr` 0, `busWData` 0, `memWrite` 0, `RegMemWrite` 0, `busError` 0, timeout counter 0. With `isLoad = isStore = 0`, `stall` reads 0.
- Strobe seen at edge 0 → `busReq` high from cycle 1.
- Ack seen in REQ at edge k → DONE in cycle k+1, with `RegMemWrite` and new `memWrite` visible. IDLE at k+2.
- Minimum latency with ack in the first REQ cycle: 3 cycles from strobe to IDLE, with 2 stall cycles.
- Back-to-back accesses: the next strobe is accepted no earlier than the IDLE cycle following DONE.
- Reset mid-transaction: the registered outputs, including `busReq`, go to 0 at the reset edge. The access is abandoned and no `RegMemWrite` is issued.

## Configuration
- `MEM_ACCESS_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entering REQ and increments in each REQ cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to DONE and `busError` pulses for that DONE cycle.
  - A timed-out load returns `memWrite` = all ones with `RegMemWrite` = 1.
  - An ack in the same cycle as the limit wins: normal completion, no error.
- Undefined: no counter. REQ waits indefinitely for `busAck`, and `busError` is constant 0.

## Test plan
- Reset with `isLoad` = 1 held → `busReq` = 0, `memWrite` = 0, `RegMemWrite` = 0 during reset. `stall` = 0 during reset; after release the load starts and `stall` goes high.
- Load, `memRead` = 8'h2A, ack after 2 REQ cycles with `busRData` = 8'h02 → `busAddr` = 8'h2A, `busWe` = 0. `memWrite` = 8'h02 with `RegMemWrite` = 1 for exactly one cycle. `stall` is high for 3 cycles.
- Store, `memRead` = 8'h10, `storeData` = 8'h55, immediate ack → `busWe` = 1, `busWData` = 8'h55. `RegMemWrite` stays 0 and `memWrite` is unchanged.
- `isLoad` and `isStore` both high, then a spurious `busAck` while IDLE → the access is a store (`busWe` = 1). The IDLE-time ack causes no state change.
- Reset asserted in the second REQ cycle → `busReq` = 0 after that edge, with no `RegMemWrite` pulse.
- With `MEM_ACCESS_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4, load with no ack → after 4 REQ cycles: DONE, `busError` = 1, `memWrite` = 8'hFF, `RegMemWrite` = 1. Without the macro, `busReq` stays high after 20 cycles.
